conv_stream_bridge: RTL and testbench

- Parametrised successor to the fixed-width GPIO-to-accelerator glue.
- Turns host (Zynq GPIO) bit-banged transfers into a valid/ready stream into the convolution accelerator, and turns accelerator results back into host reads.
- Buffers each direction in its own FIFO.
- Runs the accelerator through an IDLE/RUN/DRAIN sequence with start and done handshakes.
- Sits between the processor wrapper and ConvolutionAccelerator; everything is in one clock domain.

---
 rtl/conv_stream_bridge.sv | 233 +++++++++++++++++++++++
 tb/tb_conv_stream_bridge.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_stream_bridge.sv
// Host strobe interface <-> valid/ready stream bridge for the convolution accelerator.
// Optional sticky error flags are built only when CONV_BRIDGE_ERR_EN is defined.
//
// state  | meaning
// S_IDLE | accelerator parked; host may preload the input FIFO
// S_RUN  | streaming input FIFO while host_start is held
// S_DRAIN| streaming remaining words, then waiting for acc_done
module conv_stream_bridge #(
  parameter int DATA_W    = 16,
  parameter int IN_DEPTH  = 16,
  parameter int OUT_DEPTH = 16
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              host_rst,
  input  logic [DATA_W-1:0] host_data,
  input  logic              host_newline,
  input  logic              host_wr,
  input  logic              host_rd,
  input  logic              host_io_clk,
  input  logic              host_start,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_full_in,
  output logic              host_empty_in,
  output logic              host_full_out,
  output logic              host_empty_out,
  output logic              busy,
  output logic              acc_start,
  output logic [DATA_W-1:0] acc_data,
  output logic              acc_newline,
  output logic              acc_valid,
  input  logic              acc_ready,
  input  logic [DATA_W-1:0] acc_res,
  input  logic              acc_res_valid,
  output logic              acc_res_ready,
  input  logic              acc_done,
  output logic              err_ovf,
  output logic              err_udf
);

  localparam int IN_AW  = $clog2(IN_DEPTH);
  localparam int IN_CW  = $clog2(IN_DEPTH + 1);
  localparam int OUT_AW = $clog2(OUT_DEPTH);
  localparam int OUT_CW = $clog2(OUT_DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t              r_state;
  logic                r_busy;
  logic                r_acc_start;
  logic                r_io_q;
  logic                r_start_q;

  logic [DATA_W:0]     r_in_mem [IN_DEPTH];
  logic [IN_AW-1:0]    r_in_wp;
  logic [IN_AW-1:0]    r_in_rp;
  logic [IN_CW-1:0]    r_in_cnt;
  logic                r_in_full;
  logic                r_in_empty;

  logic [DATA_W-1:0]   r_out_mem [OUT_DEPTH];
  logic [OUT_AW-1:0]   r_out_wp;
  logic [OUT_AW-1:0]   r_out_rp;
  logic [OUT_CW-1:0]   r_out_cnt;
  logic                r_out_full;
  logic                r_out_empty;
  logic [DATA_W-1:0]   r_rdata;

  logic                w_strobe;
  logic                w_in_push;
  logic                w_in_pop;
  logic                w_out_push;
  logic                w_out_pop;
  logic                w_res_ready;
  logic                w_streaming;
  logic [DATA_W:0]     w_in_head;
  logic [IN_CW-1:0]    w_in_cnt_nxt;
  logic [OUT_CW-1:0]   w_out_cnt_nxt;

  assign w_strobe    = host_io_clk & ~r_io_q;
  assign w_streaming = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign w_in_push   = w_strobe & host_wr & ~r_in_full;
  assign w_in_pop    = w_streaming & ~r_in_empty & acc_ready;
  assign w_out_pop   = w_strobe & host_rd & ~r_out_empty;
  // A host pop frees a slot in the same cycle, so a full FIFO still takes a result then.
  assign w_res_ready = ~r_out_full | w_out_pop;
  assign w_out_push  = acc_res_valid & w_res_ready;

  assign w_in_cnt_nxt  = r_in_cnt + IN_CW'(w_in_push) - IN_CW'(w_in_pop);
  assign w_out_cnt_nxt = r_out_cnt + OUT_CW'(w_out_push) - OUT_CW'(w_out_pop);
  assign w_in_head     = r_in_mem[r_in_rp];

  assign host_rdata     = r_rdata;
  assign host_full_in   = r_in_full;
  assign host_empty_in  = r_in_empty;
  assign host_full_out  = r_out_full;
  assign host_empty_out = r_out_empty;
  assign busy           = r_busy;
  assign acc_start      = r_acc_start;
  assign acc_valid      = w_streaming & ~r_in_empty;
  assign acc_data       = r_in_empty ? '0 : w_in_head[DATA_W-1:0];
  assign acc_newline    = r_in_empty ? 1'b0 : w_in_head[DATA_W];
  assign acc_res_ready  = w_res_ready;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_io_q    <= 1'b0;
      r_start_q <= 1'b0;
    end else if (host_rst) begin
      r_io_q    <= 1'b0;
      r_start_q <= 1'b0;
    end else begin
      r_io_q    <= host_io_clk;
      r_start_q <= host_start;
    end
  end

  always_ff @(posedge Clk) begin
    if (w_in_push) r_in_mem[r_in_wp] <= {host_newline, host_data};
    if (w_out_push) r_out_mem[r_out_wp] <= acc_res;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_in_wp    <= '0;
      r_in_rp    <= '0;
      r_in_cnt   <= '0;
      r_in_full  <= 1'b0;
      r_in_empty <= 1'b1;
    end else if (host_rst) begin
      r_in_wp    <= '0;
      r_in_rp    <= '0;
      r_in_cnt   <= '0;
      r_in_full  <= 1'b0;
      r_in_empty <= 1'b1;
    end else begin
      if (w_in_push) r_in_wp <= r_in_wp + 1'b1;
      if (w_in_pop)  r_in_rp <= r_in_rp + 1'b1;
      r_in_cnt   <= w_in_cnt_nxt;
      r_in_full  <= (w_in_cnt_nxt == IN_CW'(IN_DEPTH));
      r_in_empty <= (w_in_cnt_nxt == '0);
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_out_wp    <= '0;
      r_out_rp    <= '0;
      r_out_cnt   <= '0;
      r_out_full  <= 1'b0;
      r_out_empty <= 1'b1;
      r_rdata     <= '0;
    end else if (host_rst) begin
      r_out_wp    <= '0;
      r_out_rp    <= '0;
      r_out_cnt   <= '0;
      r_out_full  <= 1'b0;
      r_out_empty <= 1'b1;
      r_rdata     <= '0;
    end else begin
      if (w_out_push) r_out_wp <= r_out_wp + 1'b1;
      if (w_out_pop) begin
        r_out_rp <= r_out_rp + 1'b1;
        r_rdata  <= r_out_mem[r_out_rp];
      end
      r_out_cnt   <= w_out_cnt_nxt;
      r_out_full  <= (w_out_cnt_nxt == OUT_CW'(OUT_DEPTH));
      r_out_empty <= (w_out_cnt_nxt == '0);
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_acc_start <= 1'b0;
    end else if (host_rst) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_acc_start <= 1'b0;
    end else begin
      r_acc_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (host_start && !r_start_q) begin
            r_state     <= S_RUN;
            r_busy      <= 1'b1;
            r_acc_start <= 1'b1;
          end
        end
        S_RUN: begin
          if (!host_start) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          // acc_done only counts once every queued pixel has left.
          if (r_in_empty && acc_done) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef CONV_BRIDGE_ERR_EN
  logic r_err_ovf;
  logic r_err_udf;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_err_ovf <= 1'b0;
      r_err_udf <= 1'b0;
    end else if (host_rst) begin
      r_err_ovf <= 1'b0;
      r_err_udf <= 1'b0;
    end else begin
      if (w_strobe && host_wr && r_in_full)   r_err_ovf <= 1'b1;
      if (w_strobe && host_rd && r_out_empty) r_err_udf <= 1'b1;
    end
  end

  assign err_ovf = r_err_ovf;
  assign err_udf = r_err_udf;
`else
  assign err_ovf = 1'b0;
  assign err_udf = 1'b0;
`endif

endmodule

// File: tb/tb_conv_stream_bridge.sv
// Scoreboard bench for conv_stream_bridge: queue-based reference model updated on each
// clock edge, monitor compares DUT outputs on the falling edge.
`timescale 1ns/1ps
module tb_conv_stream_bridge;
  localparam int DW = 16;
  localparam int ID = 4;
  localparam int OD = 4;

  logic          Clk = 1'b0;
  logic          Rst_n = 1'b0;
  logic          host_rst = 1'b0;
  logic [DW-1:0] host_data = '0;
  logic          host_newline = 1'b0;
  logic          host_wr = 1'b0;
  logic          host_rd = 1'b0;
  logic          host_io_clk = 1'b0;
  logic          host_start = 1'b0;
  logic [DW-1:0] host_rdata;
  logic          host_full_in, host_empty_in, host_full_out, host_empty_out;
  logic          busy, acc_start;
  logic [DW-1:0] acc_data;
  logic          acc_newline, acc_valid;
  logic          acc_ready = 1'b0;
  logic [DW-1:0] acc_res = '0;
  logic          acc_res_valid = 1'b0;
  logic          acc_res_ready;
  logic          acc_done = 1'b0;
  logic          err_ovf, err_udf;

  always #5 Clk = ~Clk;

  conv_stream_bridge #(.DATA_W(DW), .IN_DEPTH(ID), .OUT_DEPTH(OD)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .host_rst(host_rst), .host_data(host_data),
    .host_newline(host_newline), .host_wr(host_wr), .host_rd(host_rd),
    .host_io_clk(host_io_clk), .host_start(host_start), .host_rdata(host_rdata),
    .host_full_in(host_full_in), .host_empty_in(host_empty_in),
    .host_full_out(host_full_out), .host_empty_out(host_empty_out),
    .busy(busy), .acc_start(acc_start), .acc_data(acc_data), .acc_newline(acc_newline),
    .acc_valid(acc_valid), .acc_ready(acc_ready), .acc_res(acc_res),
    .acc_res_valid(acc_res_valid), .acc_res_ready(acc_res_ready), .acc_done(acc_done),
    .err_ovf(err_ovf), .err_udf(err_udf)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

`ifdef CONV_BRIDGE_ERR_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  // Reference model: phase 0 idle, 1 run, 2 drain.
  logic [DW:0]   m_in[$];
  logic [DW-1:0] m_out[$];
  int            m_phase = 0;
  bit            m_start_pulse = 0, m_io_prev = 0, m_start_prev = 0, m_ovf = 0, m_udf = 0;
  logic [DW-1:0] m_rdata = '0;

  always @(posedge Clk or negedge Rst_n) begin
    int  in_sz, out_sz;
    bit  stb, rd_pop;
    logic [DW-1:0] tmp;
    if (!Rst_n || host_rst) begin
      m_in.delete(); m_out.delete();
      m_phase = 0; m_start_pulse = 0; m_io_prev = 0; m_start_prev = 0;
      m_ovf = 0; m_udf = 0; m_rdata = '0;
    end else begin
      in_sz  = m_in.size();
      out_sz = m_out.size();
      stb    = host_io_clk && !m_io_prev;
      if (m_phase != 0 && in_sz > 0 && acc_ready) void'(m_in.pop_front());
      if (stb && host_wr) begin
        if (in_sz < ID) m_in.push_back({host_newline, host_data});
        else if (ERR_ON) m_ovf = 1;
      end
      rd_pop = stb && host_rd && out_sz > 0;
      if (rd_pop) begin
        tmp = m_out.pop_front();
        m_rdata = tmp;
      end else if (stb && host_rd && ERR_ON) m_udf = 1;
      if (acc_res_valid && (out_sz < OD || rd_pop)) m_out.push_back(acc_res);
      m_start_pulse = 0;
      case (m_phase)
        0: if (host_start && !m_start_prev) begin m_phase = 1; m_start_pulse = 1; end
        1: if (!host_start) m_phase = 2;
        default: if (in_sz == 0 && acc_done) m_phase = 0;
      endcase
      m_io_prev    = host_io_clk;
      m_start_prev = host_start;
    end
  end

  always @(negedge Clk) begin
    bit exp_valid, stb;
    logic [DW:0] hd;
    if (Rst_n) begin
      exp_valid = (m_phase != 0) && (m_in.size() > 0);
      stb = host_io_clk && !m_io_prev;
      chk("busy", busy, m_phase != 0);
      chk("acc_valid", acc_valid, exp_valid);
      if (exp_valid && acc_valid) begin
        hd = m_in[0];
        chk("acc_data", acc_data, hd[DW-1:0]);
        chk("acc_newline", acc_newline, hd[DW]);
      end
      chk("acc_start", acc_start, m_start_pulse);
      chk("empty_in", host_empty_in, m_in.size() == 0);
      chk("full_in", host_full_in, m_in.size() == ID);
      chk("empty_out", host_empty_out, m_out.size() == 0);
      chk("full_out", host_full_out, m_out.size() == OD);
      chk("host_rdata", host_rdata, m_rdata);
      chk("err_ovf", err_ovf, m_ovf);
      chk("err_udf", err_udf, m_udf);
      chk("acc_res_ready", acc_res_ready,
          (m_out.size() < OD) || (stb && host_rd && m_out.size() > 0));
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic strobe(input bit wr, input bit rd, input logic [DW-1:0] d, input bit nl);
    host_wr = wr; host_rd = rd; host_data = d; host_newline = nl;
    host_io_clk = 1'b1;
    tick();
    host_io_clk = 1'b0; host_wr = 1'b0; host_rd = 1'b0;
    tick();
  endtask

  task automatic finish_run();
    host_start = 1'b0;
    repeat (2) tick();
    acc_done = 1'b1;
    tick();
    acc_done = 1'b0;
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_empty_in", host_empty_in, 1);
    chk("rst_empty_out", host_empty_out, 1);
    chk("rst_res_ready", acc_res_ready, 1);
    chk("rst_rdata", host_rdata, 0);
    chk("rst_acc_data", acc_data, 0);
    Rst_n = 1'b1;
    tick();

    strobe(1, 0, 16'h0011, 0);
    strobe(1, 0, 16'h0022, 0);
    strobe(1, 0, 16'h0033, 1);
    chk("preload_valid", acc_valid, 0);
    chk("preload_empty_in", host_empty_in, 0);

    acc_ready = 1'b1;
    host_start = 1'b1;
    repeat (6) tick();
    chk("stream_empty_in", host_empty_in, 1);
    host_start = 1'b0;
    repeat (2) tick();
    chk("drain_busy", busy, 1);
    acc_done = 1'b1;
    tick();
    acc_done = 1'b0;
    chk("done_busy", busy, 0);

    acc_res_valid = 1'b1; acc_res = 16'h0A0A;
    tick();
    acc_res = 16'h0B0B;
    tick();
    acc_res_valid = 1'b0;
    strobe(0, 1, '0, 0);
    chk("read1", host_rdata, 16'h0A0A);
    strobe(0, 1, '0, 0);
    chk("read2", host_rdata, 16'h0B0B);

    for (int i = 0; i < 5; i++) strobe(1, 0, DW'(16'h0100 + i), i == 3);
    chk("ovf_full_in", host_full_in, 1);
    chk("ovf_flag", err_ovf, ERR_ON);
    host_start = 1'b1;
    repeat (8) tick();
    finish_run();
    tick();
    chk("ovf_idle", busy, 0);

    strobe(0, 1, '0, 0);
    chk("udf_hold", host_rdata, 16'h0B0B);
    chk("udf_flag", err_udf, ERR_ON);
    acc_res_valid = 1'b1; acc_res = 16'h0C0C;
    tick();
    acc_res_valid = 1'b0;
    host_rst = 1'b1;
    tick();
    host_rst = 1'b0;
    chk("hrst_ovf", err_ovf, 0);
    chk("hrst_udf", err_udf, 0);
    chk("hrst_empty_out", host_empty_out, 1);
    chk("hrst_empty_in", host_empty_in, 1);

    host_wr = 1'b1; host_data = 16'h0777; host_io_clk = 1'b1;
    repeat (10) tick();
    host_io_clk = 1'b0; host_wr = 1'b0;
    tick();
    chk("hold_empty_in", host_empty_in, 0);
    host_start = 1'b1;
    repeat (3) tick();
    chk("hold_one_push", host_empty_in, 1);
    finish_run();
    tick();

    for (int c = 0; c < 3000; c++) begin
      host_io_clk   = 1'($urandom_range(0, 1));
      host_wr       = 1'($urandom_range(0, 1));
      host_rd       = 1'($urandom_range(0, 1));
      host_data     = DW'($urandom);
      host_newline  = 1'($urandom_range(0, 1));
      acc_ready     = ($urandom_range(0, 3) != 0);
      acc_res_valid = 1'($urandom_range(0, 1));
      acc_res       = DW'($urandom);
      acc_done      = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 40) == 0) host_start = ~host_start;
      host_rst      = ($urandom_range(0, 500) == 0);
      tick();
    end
    host_io_clk = 0; host_wr = 0; host_rd = 0; acc_res_valid = 0;
    acc_done = 0; host_rst = 0; host_start = 0; acc_ready = 0;
    repeat (3) tick();
    host_rst = 1'b1;
    tick();
    host_rst = 1'b0;
    tick();

    strobe(1, 0, 16'h0055, 0);
    strobe(1, 0, 16'h0066, 0);
    host_start = 1'b1;
    repeat (2) tick();
    chk("run_busy", busy, 1);
    chk("run_valid", acc_valid, 1);
    @(posedge Clk);
    #3;
    Rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_valid", acc_valid, 0);
    chk("arst_empty_in", host_empty_in, 1);
    chk("arst_acc_data", acc_data, 0);
    chk("arst_res_ready", acc_res_ready, 1);
    host_start = 1'b0;
    tick();
    Rst_n = 1'b1;
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
